// File: rtl/memc_req_scheduler.sv
// rtl/memc_req_scheduler.sv - arbitrates cache-line transfer commands onto the memory-controller command port
module memc_req_scheduler #(
    parameter int NUM_REQ   = 3,
    parameter int NUM_TRANS = 4,
    parameter int MAX_OUT   = 2,
    parameter int CLSIZE_E  = 6,
    localparam int IDW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int TAGW     = (NUM_TRANS > 1) ? $clog2(NUM_TRANS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0][1:0]       req_cmd,
    input  logic [NUM_REQ-1:0][31:0]      req_read_addr,
    input  logic [NUM_REQ-1:0][31:0]      req_write_addr,
    input  logic [NUM_REQ-1:0][15:0]      req_cache_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          mem_valid,
    output logic [1:0]                    mem_cmd,
    output logic [31:0]                   mem_read_addr,
    output logic [31:0]                   mem_write_addr,
    output logic [15:0]                   mem_cache_addr,
    output logic [IDW-1:0]                mem_id,
    output logic [TAGW-1:0]               mem_tag,
    input  logic                          mem_stall,
    input  logic                          cpl_valid,
    input  logic [TAGW-1:0]               cpl_tag,
    output logic                          busy
);

    localparam int CNTW  = $clog2(MAX_OUT + 1);
    localparam int LINEW = 32 - CLSIZE_E;

    // Tag table: one entry per in-flight transfer
    logic [NUM_TRANS-1:0]  occ;
    logic [IDW-1:0]        slot_id    [NUM_TRANS];
    logic [1:0]            slot_cmd   [NUM_TRANS];
    logic [LINEW-1:0]      slot_rline [NUM_TRANS];
    logic [LINEW-1:0]      slot_wline [NUM_TRANS];

    logic [CNTW-1:0]       out_cnt [NUM_REQ];
    logic [IDW-1:0]        rr_ptr;

    logic                  load_ok;
    logic                  free_any;
    logic [TAGW-1:0]       free_idx;
    logic [NUM_REQ-1:0]    hazard;
    logic [NUM_REQ-1:0]    eligible;
    logic                  grant_any;
    logic [IDW-1:0]        grant_id;
    logic                  cpl_hit;
    logic [IDW-1:0]        cpl_id;

    // Output register may take a new command when empty or being handed off
    always_comb begin
        load_ok = !mem_valid || !mem_stall;
    end

    // Lowest-index free slot; a slot completing this cycle still counts as occupied
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int t = NUM_TRANS - 1; t >= 0; t--) begin
            if (!occ[t]) begin
                free_any = 1'b1;
                free_idx = TAGW'(t);
            end
        end
    end

    // RAW/WAR hazard against every occupied slot, regardless of which requester owns it
    always_comb begin
        hazard = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int t = 0; t < NUM_TRANS; t++) begin
                if (occ[t]) begin
                    if (req_cmd[i][0] && slot_cmd[t][1] &&
                        slot_wline[t] == req_read_addr[i][31:CLSIZE_E]) begin
                        hazard[i] = 1'b1;
                    end
                    if (req_cmd[i][1] && slot_cmd[t][0] &&
                        slot_rline[t] == req_write_addr[i][31:CLSIZE_E]) begin
                        hazard[i] = 1'b1;
                    end
                end
            end
        end
    end

    // Per-requester eligibility; cmd NONE is never granted
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = !rst && req_valid[i] && (req_cmd[i] != 2'd0) &&
                          (out_cnt[i] < CNTW'(MAX_OUT)) && free_any &&
                          !hazard[i] && load_ok;
        end
    end

    // Round-robin pick: first eligible index at or after rr_ptr
    always_comb begin
        logic [IDW:0] sum;
        logic [IDW-1:0] idx;
        grant_any = 1'b0;
        grant_id  = '0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr} + (IDW + 1)'(k);
            if (sum >= (IDW + 1)'(NUM_REQ)) begin
                sum = sum - (IDW + 1)'(NUM_REQ);
            end
            idx = sum[IDW-1:0];
            if (!grant_any && eligible[idx]) begin
                grant_any = 1'b1;
                grant_id  = idx;
            end
        end
    end

    // One-hot grant back to the requesters
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = grant_any && (grant_id == IDW'(i));
        end
    end

    // Completion is honoured only for an occupied slot
    always_comb begin
        cpl_hit = cpl_valid && occ[cpl_tag];
        cpl_id  = slot_id[cpl_tag];
    end

    // Slot occupancy: allocate on grant, free on completion
    always_ff @(posedge clk) begin
        if (rst) begin
            occ <= '0;
        end else begin
            if (cpl_hit) begin
                occ[cpl_tag] <= 1'b0;
            end
            if (grant_any) begin
                occ[free_idx] <= 1'b1;
            end
        end
    end

    // Slot payload captured at allocation
    always_ff @(posedge clk) begin
        if (grant_any) begin
            slot_id[free_idx]    <= grant_id;
            slot_cmd[free_idx]   <= req_cmd[grant_id];
            slot_rline[free_idx] <= req_read_addr[grant_id][31:CLSIZE_E];
            slot_wline[free_idx] <= req_write_addr[grant_id][31:CLSIZE_E];
        end
    end

    // Per-requester outstanding counters; grant and completion in one cycle cancel
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst) begin
                out_cnt[i] <= '0;
            end else begin
                if ((grant_any && grant_id == IDW'(i)) && !(cpl_hit && cpl_id == IDW'(i))) begin
                    out_cnt[i] <= out_cnt[i] + CNTW'(1);
                end else if (!(grant_any && grant_id == IDW'(i)) && (cpl_hit && cpl_id == IDW'(i))) begin
                    out_cnt[i] <= out_cnt[i] - CNTW'(1);
                end
            end
        end
    end

    // Round-robin pointer moves past the most recent winner
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            rr_ptr <= (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);
        end
    end

    // Output command valid and cmd; cleared on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid <= 1'b0;
            mem_cmd   <= 2'd0;
        end else if (load_ok) begin
            mem_valid <= grant_any;
            if (grant_any) begin
                mem_cmd <= req_cmd[grant_id];
            end
        end
    end

    // Output command payload; only meaningful while mem_valid
    always_ff @(posedge clk) begin
        if (grant_any) begin
            mem_read_addr  <= req_read_addr[grant_id];
            mem_write_addr <= req_write_addr[grant_id];
            mem_cache_addr <= req_cache_addr[grant_id];
            mem_id         <= grant_id;
            mem_tag        <= free_idx;
        end
    end

    // Activity indication
    always_comb begin
        busy = (|occ) || mem_valid;
    end

    // Completion must name an in-flight tag
    a_cpl_occupied: assert property (@(posedge clk) disable iff (rst) cpl_valid |-> occ[cpl_tag]);

    // A valid request must carry a real command
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cmd_chk
        a_cmd_legal: assert property (@(posedge clk) disable iff (rst) req_valid[g] |-> (req_cmd[g] != 2'd0));
    end

endmodule

// File: doc/memc_req_scheduler.md
# memc_req_scheduler

Arbitrates cache-line transfer commands from up to NUM_REQ cache line managers (ICache, DCache, prefetch) onto the single memory-controller command port. It tracks every in-flight transfer in a tag table and enforces per-requester and global outstanding limits. It blocks read-after-write and write-after-read hazards on the same cache line across requesters. It sits between the cache line managers and the memory controller.

## Interface
- NUM_REQ, 3, number of requesters (2..8)
- NUM_TRANS, 4, in-flight transfer slots (tags); power of two
- MAX_OUT, 2, max in-flight transfers per requester (1..NUM_TRANS)
- CLSIZE_E, 6, log2 cache line bytes; line address = addr[31:CLSIZE_E]
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  request present per requester
- req_cmd  in  NUM_REQ x 2  0 NONE (illegal with valid), 1 READ ext->cache, 2 WRITE cache->ext, 3 REPLACE (write then read)
- req_read_addr / req_write_addr  in  NUM_REQ x 32  byte addresses; meaningful per cmd
- req_cache_addr  in  NUM_REQ x 16  cache SRAM word address, passed through
- req_ready  out  NUM_REQ  one-hot grant, combinational, same cycle
- mem_valid  out  1  registered command valid
- mem_cmd, mem_read_addr, mem_write_addr, mem_cache_addr  out  2/32/32/16  registered command fields
- mem_id  out  clog2(NUM_REQ)  granted requester
- mem_tag  out  clog2(NUM_TRANS)  allocated slot
- mem_stall  in  1  controller cannot accept command this cycle
- cpl_valid  in  1  transfer complete
- cpl_tag  in  clog2(NUM_TRANS)  tag of completed transfer
- busy  out  1  any slot occupied or mem_valid

## Operation
- Output register: loadable when !mem_valid || !mem_stall. Handoff occurs in a cycle with mem_valid && !mem_stall.
- Eligible i: req_valid[i], out_cnt[i] < MAX_OUT, a free slot exists, no hazard, output register loadable.
- Hazard: i's read line (READ/REPLACE) equals the write line of any occupied WRITE/REPLACE slot, or i's write line (WRITE/REPLACE) equals the read line of any occupied READ/REPLACE slot.
- Grant: first eligible index scanning from rr_ptr upward, modulo NUM_REQ. At most one grant per cycle. req_ready[granted]=1; all others 0.
- On grant, the following all take effect: the output register loads the fields, mem_id, and mem_tag = lowest free slot index; the slot is marked occupied with {id, cmd, read line, write line}; out_cnt[id]++; rr_ptr <= id+1 mod NUM_REQ.
- Completion: on cpl_valid, slot cpl_tag is freed and out_cnt[slot.id]-- takes effect next cycle. Within the same cycle, the completing slot still counts as occupied for the free-slot search, the hazard check, and the out_cnt limit.
- Grant and completion for the same requester in one cycle: net out_cnt change 0.
- cpl_valid on a free slot, or req_cmd==0 with valid: illegal; simulation assertion; no state change.
- busy = |occupied || mem_valid.

## Timing
- Reset values: mem_valid=0; mem_cmd=0; other mem_* fields X; all slots free; out_cnt=0; rr_ptr=0; req_ready=0 (comb, since no slot state blocks but req_valid is gated by rst); busy=0.
- Latency: grant in cycle N; mem_valid=1 in N+1; handoff in the first cycle from N+1 onward where mem_stall=0.
- While mem_valid && mem_stall, req_ready is all 0 and the output holds its fields stably.
- Back-to-back: with mem_stall=0 throughput is one command per cycle until slots or per-requester limits are exhausted.
- Slot freed at cycle N becomes allocatable at N+1.
- rst mid-operation clears all slots and the output register. Completions for pre-reset tags are illegal.

## Test plan
- Reset, then req_valid=3'b111 all READ to distinct lines, mem_stall=0, NUM_TRANS=4, MAX_OUT=2. Grants go 0,1,2 on consecutive cycles; mem_tag 0,1,2; fourth grant to 0 with tag 3; next cycle all blocked (no free slot).
- Requester 0 at limit (out_cnt=2) with req 1 valid: only 1 granted. cpl_valid for 0's tag and a new req 0 in the same cycle: not granted; granted next cycle.
- Req 0 WRITE to line 0x80000040 in flight; req 1 READ 0x80000044: held, req_ready[1]=0. cpl for that tag at cycle N: req 1 is granted at N+1.
- mem_stall held high 5 cycles with mem_valid=1: fields are constant, req_ready=0; mem_stall drops, handoff, new grant the same cycle.
- REPLACE with read line A / write line B in flight: a READ of B, and a WRITE to A, both blocked; a READ of C is granted.
- Assert rst with 3 slots occupied and mem_valid=1: next cycle busy=0, mem_valid=0, the first grant gets tag 0 and goes to requester 0.
